// File: rtl/pdsch_decoder_crc_pair_feeder.sv
// Serialises decoder words into 2-bit pairs (parity-flagged) for the CRC24 checker; pair out 1 cycle after select, done 2 cycles after last pair.
// Backpressure: o_word_rdy only when the holding register frees up in FEED; optional i_abort via PDSCH_CRC_FEED_ABORT_EN.
module pdsch_decoder_crc_pair_feeder #(
    parameter int DW      = 32,
    parameter int KW      = 14,
    parameter int CRC_LEN = 24
) (
    input  logic          i_sys_200_clk,
    input  logic          i_rstn,
    input  logic          i_cb_start,
    input  logic [KW-1:0] i_cb_len,
    input  logic [DW-1:0] i_word,
    input  logic          i_word_vld,
    output logic          o_word_rdy,
    output logic          o_crc_decode_start,
    output logic [1:0]    o_din,
    output logic          o_din_vld,
    output logic          o_parity_vld,
    input  logic          i_crc_status,
`ifdef PDSCH_CRC_FEED_ABORT_EN
    input  logic          i_abort,
`endif
    output logic          o_busy,
    output logic          o_cb_done,
    output logic          o_cb_crc_fail,
    output logic          o_len_err
);

    localparam int          PW        = (DW / 2 > 1) ? $clog2(DW / 2) : 1;
    localparam logic [PW-1:0] LAST_IDX  = PW'(DW / 2 - 1);
    localparam logic [KW-1:0] MIN_LEN   = KW'(CRC_LEN + 2);
    localparam logic [KW-1:0] PAR_PAIRS = KW'(CRC_LEN / 2);

    typedef enum logic [2:0] {IDLE, START, FEED, FLUSH, DONE} state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] hold;
    logic          full;
    logic [PW-1:0] idx;
    logic [KW-1:0] pair_rem;
    logic          status;
    logic          fail;
    logic          abort;
    logic          len_ok;
    logic          emit;
    logic          last_rem;
    logic          word_end;
    logic          word_rdy;

`ifdef PDSCH_CRC_FEED_ABORT_EN
    assign abort = i_abort & (state != IDLE);
`else
    assign abort = 1'b0;
`endif

    assign len_ok   = ~i_cb_len[0] & (i_cb_len >= MIN_LEN);
    assign emit     = (state == FEED) & full & (pair_rem != '0);
    assign last_rem = (pair_rem == KW'(1));
    assign word_end = (idx == LAST_IDX);

    always_comb begin
        state_nxt = state;
        word_rdy  = 1'b0;
        case (state)
            IDLE:  if (i_cb_start && len_ok) state_nxt = START;
            START: state_nxt = FEED;
            FEED: begin
                if (pair_rem == '0) state_nxt = FLUSH;
                // Refill only while the block still needs bits, so no word straddles two blocks.
                word_rdy = (pair_rem != '0) & (~full | (word_end & ~last_rem));
            end
            FLUSH: state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort) begin
            state_nxt = IDLE;
            word_rdy  = 1'b0;
        end
    end

    assign o_word_rdy         = word_rdy;
    assign o_crc_decode_start = (state == START);
    assign o_busy             = (state != IDLE);
    assign o_cb_done          = (state == DONE) & ~abort;
    assign o_cb_crc_fail      = o_cb_done ? status : fail;

    always_ff @(posedge i_sys_200_clk or negedge i_rstn) begin
        if (!i_rstn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_ff @(posedge i_sys_200_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            hold         <= '0;
            full         <= 1'b0;
            idx          <= '0;
            pair_rem     <= '0;
            o_din        <= 2'b00;
            o_din_vld    <= 1'b0;
            o_parity_vld <= 1'b0;
            status       <= 1'b0;
            fail         <= 1'b0;
            o_len_err    <= 1'b0;
        end else begin
            o_len_err    <= (state == IDLE) & i_cb_start & ~len_ok;
            o_din_vld    <= emit & ~abort;
            o_parity_vld <= emit & ~abort & (pair_rem <= PAR_PAIRS);
            if (emit) o_din <= hold[{idx, 1'b0} +: 2];

            if (state == IDLE && i_cb_start && len_ok) pair_rem <= i_cb_len >> 1;
            else if (emit)                             pair_rem <= pair_rem - KW'(1);

            if (state != FEED || abort) begin
                full <= 1'b0;
                idx  <= '0;
            end else if (i_word_vld && word_rdy) begin
                hold <= i_word;
                full <= 1'b1;
                idx  <= '0;
            end else if (emit) begin
                // Last pair of the block drops any unused upper bits of the word.
                if (word_end || last_rem) begin
                    full <= 1'b0;
                    idx  <= '0;
                end else begin
                    idx <= idx + PW'(1);
                end
            end

            if (state == FLUSH) status <= i_crc_status;
            if (o_cb_done)      fail   <= status;
        end
    end

endmodule

// File: tb/tb_pdsch_decoder_crc_pair_feeder.sv
// Bench for pdsch_decoder_crc_pair_feeder: emulates the CRC24A pair checker and scores pairs against the bit stream.
`timescale 1ns/1ps
module tb_pdsch_decoder_crc_pair_feeder;
    localparam int DW = 32;
    localparam int KW = 14;
    localparam int CRC_LEN = 24;
    localparam logic [23:0] POLY = 24'h864CFB;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          cb_start = 1'b0;
    logic [KW-1:0] cb_len = '0;
    logic [DW-1:0] word = '0;
    logic          word_vld = 1'b0;
    logic          word_rdy, crc_decode_start, din_vld, parity_vld;
    logic [1:0]    din;
    logic          crc_status;
    logic          busy, cb_done, cb_crc_fail, len_err;
`ifdef PDSCH_CRC_FEED_ABORT_EN
    logic          abort = 1'b0;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    bit last_exp_fail = 1'b0;

    always #5 clk = ~clk;

    pdsch_decoder_crc_pair_feeder #(.DW(DW), .KW(KW), .CRC_LEN(CRC_LEN)) dut (
        .i_sys_200_clk     (clk),
        .i_rstn            (rstn),
        .i_cb_start        (cb_start),
        .i_cb_len          (cb_len),
        .i_word            (word),
        .i_word_vld        (word_vld),
        .o_word_rdy        (word_rdy),
        .o_crc_decode_start(crc_decode_start),
        .o_din             (din),
        .o_din_vld         (din_vld),
        .o_parity_vld      (parity_vld),
        .i_crc_status      (crc_status),
`ifdef PDSCH_CRC_FEED_ABORT_EN
        .i_abort           (abort),
`endif
        .o_busy            (busy),
        .o_cb_done         (cb_done),
        .o_cb_crc_fail     (cb_crc_fail),
        .o_len_err         (len_err)
    );

    function automatic logic [23:0] crc_step(input logic [23:0] c, input logic b);
        return {c[22:0], 1'b0} ^ ((c[23] ^ b) ? POLY : 24'h0);
    endfunction

    // External checker: clears on start pulse, folds in each valid pair, registered fail flag.
    logic [23:0] chk_crc;
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            chk_crc    <= '0;
            crc_status <= 1'b0;
        end else if (crc_decode_start) begin
            chk_crc    <= '0;
            crc_status <= 1'b0;
        end else if (din_vld) begin
            chk_crc    <= crc_step(crc_step(chk_crc, din[0]), din[1]);
            crc_status <= (crc_step(crc_step(chk_crc, din[0]), din[1]) != 24'h0);
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    logic [1:0] pair_dat_q[$];
    bit         pair_par_q[$];
    int         pair_cyc_q[$];
    int         done_cyc_q[$];
    bit         done_fail_q[$];
    int         start_cyc_q[$];
    int         lenerr_cnt = 0;

    always @(negedge clk) begin
        if (rstn) begin
            if (din_vld) begin
                pair_dat_q.push_back(din);
                pair_par_q.push_back(parity_vld);
                pair_cyc_q.push_back(cyc);
            end
            if (cb_done) begin
                done_cyc_q.push_back(cyc);
                done_fail_q.push_back(cb_crc_fail);
            end
            if (crc_decode_start) start_cyc_q.push_back(cyc);
            if (len_err) lenerr_cnt <= lenerr_cnt + 1;
        end
    end

    logic [DW-1:0] blk_words[$];
    bit            blk_bits[$];

    task automatic pack_words(input int len);
        blk_words.delete();
        for (int w = 0; w < (len + DW - 1) / DW; w++) begin
            logic [DW-1:0] wd;
            wd = $urandom;
            for (int b = 0; b < DW; b++)
                if (w * DW + b < len) wd[b] = blk_bits[w * DW + b];
            blk_words.push_back(wd);
        end
    endtask

    task automatic make_random(input int len, input bit corrupt);
        logic [23:0] c;
        int p;
        blk_bits.delete();
        c = '0;
        for (int i = 0; i < len - CRC_LEN; i++) blk_bits.push_back(1'($urandom_range(0, 1)));
        foreach (blk_bits[i]) c = crc_step(c, blk_bits[i]);
        for (int k = 23; k >= 0; k--) blk_bits.push_back(c[k]);
        if (corrupt) begin
            p = len - 1 - $urandom_range(0, CRC_LEN - 1);
            blk_bits[p] = !blk_bits[p];
        end
        pack_words(len);
    endtask

    function automatic bit block_fails();
        logic [23:0] c;
        c = '0;
        foreach (blk_bits[i]) c = crc_step(c, blk_bits[i]);
        return (c != 24'h0);
    endfunction

    task automatic start_block(input int len);
        @(posedge clk); #1;
        cb_start = 1'b1;
        cb_len   = KW'(len);
        @(posedge clk); #1;
        cb_start = 1'b0;
        cb_len   = '0;
        word     = blk_words[0];
        word_vld = 1'b1;
    endtask

    task automatic feed_cycle(input bit gaps, inout int n_acc);
        bit acc;
        @(negedge clk);
        acc = word_vld && word_rdy;
        @(posedge clk); #1;
        if (acc) n_acc++;
        if (acc || !word_vld) begin
            if (n_acc < blk_words.size() && (!gaps || $urandom_range(0, 2) != 0)) begin
                word     = blk_words[n_acc];
                word_vld = 1'b1;
            end else begin
                word_vld = 1'b0;
            end
        end
    endtask

    task automatic run_block(input int len, input bit gaps, input bit poke, input string name);
        int n_acc, budget, np, bp, bd, bs, be, npairs;
        bit exp_fail, exp_par;
        logic [1:0] exp_dat;
        bp = pair_dat_q.size(); bd = done_cyc_q.size(); bs = start_cyc_q.size(); be = lenerr_cnt;
        npairs = len / 2;
        exp_fail = block_fails();
        n_acc = 0; budget = 0;
        start_block(len);
        while (done_cyc_q.size() == bd && budget < 3000) begin
            feed_cycle(gaps, n_acc);
            budget++;
            cb_start = poke && (budget == 6);
            cb_len   = cb_start ? KW'(3) : '0;
        end
        cb_start = 1'b0;
        word_vld = 1'b0;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL %s busy_after_done: got %b want 0", name, busy); end
        n_cmp++; if (start_cyc_q.size() - bs !== 1) begin n_bad++; $display("FAIL %s start_pulses: got %0d want 1", name, start_cyc_q.size() - bs); end
        n_cmp++; if (pair_dat_q.size() - bp !== npairs) begin n_bad++; $display("FAIL %s pair_count: got %0d want %0d", name, pair_dat_q.size() - bp, npairs); end
        n_cmp++; if (n_acc !== blk_words.size()) begin n_bad++; $display("FAIL %s words_accepted: got %0d want %0d", name, n_acc, blk_words.size()); end
        np = (pair_dat_q.size() - bp < npairs) ? pair_dat_q.size() - bp : npairs;
        for (int k = 0; k < np; k++) begin
            exp_dat = {logic'(blk_bits[2 * k + 1]), logic'(blk_bits[2 * k])};
            exp_par = (k >= npairs - CRC_LEN / 2);
            n_cmp++; if (pair_dat_q[bp + k] !== exp_dat) begin n_bad++; $display("FAIL %s pair_dat[%0d]: got %b want %b", name, k, pair_dat_q[bp + k], exp_dat); end
            n_cmp++; if (pair_par_q[bp + k] !== exp_par) begin n_bad++; $display("FAIL %s parity_vld[%0d]: got %b want %b", name, k, pair_par_q[bp + k], exp_par); end
        end
        n_cmp++; if (done_cyc_q.size() - bd !== 1) begin n_bad++; $display("FAIL %s done_pulses: got %0d want 1", name, done_cyc_q.size() - bd); end
        if (done_cyc_q.size() > bd && np > 0) begin
            n_cmp++; if (done_cyc_q[bd] - pair_cyc_q[bp + np - 1] !== 2) begin n_bad++; $display("FAIL %s done_latency: got %0d want 2", name, done_cyc_q[bd] - pair_cyc_q[bp + np - 1]); end
            n_cmp++; if (done_fail_q[bd] !== exp_fail) begin n_bad++; $display("FAIL %s crc_fail_at_done: got %b want %b", name, done_fail_q[bd], exp_fail); end
        end
        n_cmp++; if (cb_crc_fail !== exp_fail) begin n_bad++; $display("FAIL %s crc_fail_held: got %b want %b", name, cb_crc_fail, exp_fail); end
        n_cmp++; if (lenerr_cnt - be !== 0) begin n_bad++; $display("FAIL %s len_err_pulses: got %0d want 0", name, lenerr_cnt - be); end
        if (!gaps && np == npairs && start_cyc_q.size() > bs) begin
            n_cmp++; if (pair_cyc_q[bp + np - 1] - pair_cyc_q[bp] !== npairs - 1) begin n_bad++; $display("FAIL %s back_to_back_span: got %0d want %0d", name, pair_cyc_q[bp + np - 1] - pair_cyc_q[bp], npairs - 1); end
            n_cmp++; if (pair_cyc_q[bp] - start_cyc_q[bs] !== 3) begin n_bad++; $display("FAIL %s first_pair_delay: got %0d want 3", name, pair_cyc_q[bp] - start_cyc_q[bs]); end
        end
        last_exp_fail = exp_fail;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if ({word_rdy, crc_decode_start, din, din_vld, parity_vld, busy, cb_done, cb_crc_fail, len_err} !== 10'b0) begin
            n_bad++; $display("FAIL reset_outputs: got %b want 0", {word_rdy, crc_decode_start, din, din_vld, parity_vld, busy, cb_done, cb_crc_fail, len_err});
        end
        @(posedge clk); #1; rstn = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if ({word_rdy, busy, din_vld} !== 3'b0) begin n_bad++; $display("FAIL idle_after_reset: got %b want 000", {word_rdy, busy, din_vld}); end
    endtask

    task automatic test_basic_len56();
        int bp;
        bp = pair_dat_q.size();
        blk_words.delete();
        blk_words.push_back(32'h0000_00A5);
        blk_words.push_back(32'h0000_0000);
        blk_bits.delete();
        for (int i = 0; i < 56; i++) blk_bits.push_back(blk_words[i / DW][i % DW]);
        run_block(56, 1'b0, 1'b0, "basic56");
        if (pair_dat_q.size() > bp) begin
            n_cmp++; if (pair_dat_q[bp] !== 2'b01) begin n_bad++; $display("FAIL basic56 first_pair: got %b want 01", pair_dat_q[bp]); end
        end
    endtask

    task automatic test_crc_pass_fail();
        int p;
        make_random(48, 1'b0);
        run_block(48, 1'b0, 1'b0, "crc_pass");
        n_cmp++; if (cb_crc_fail !== 1'b0) begin n_bad++; $display("FAIL crc_pass result: got %b want 0", cb_crc_fail); end
        p = 48 - 1 - $urandom_range(0, CRC_LEN - 1);
        blk_bits[p] = !blk_bits[p];
        pack_words(48);
        run_block(48, 1'b0, 1'b0, "crc_flip");
        n_cmp++; if (cb_crc_fail !== 1'b1) begin n_bad++; $display("FAIL crc_flip result: got %b want 1", cb_crc_fail); end
    endtask

    task automatic test_bubbles();
        int len;
        for (int i = 0; i < 6; i++) begin
            len = 2 * $urandom_range(13, 120);
            make_random(len, 1'($urandom_range(0, 1)));
            run_block(len, 1'b1, 1'b0, "bubbles");
        end
    endtask

    task automatic test_len_check();
        int bad_len[2];
        int be, bs;
        bad_len[0] = 25;
        bad_len[1] = 24;
        for (int i = 0; i < 2; i++) begin
            be = lenerr_cnt; bs = start_cyc_q.size();
            @(posedge clk); #1; cb_start = 1'b1; cb_len = KW'(bad_len[i]);
            @(posedge clk); #1; cb_start = 1'b0; cb_len = '0;
            @(negedge clk);
            n_cmp++; if (len_err !== 1'b1) begin n_bad++; $display("FAIL len_err_%0d: got %b want 1", bad_len[i], len_err); end
            n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL len_busy_%0d: got %b want 0", bad_len[i], busy); end
            @(negedge clk);
            n_cmp++; if (len_err !== 1'b0) begin n_bad++; $display("FAIL len_err_pulse_%0d: got %b want 0", bad_len[i], len_err); end
            n_cmp++; if (start_cyc_q.size() - bs !== 0 || lenerr_cnt - be !== 1) begin
                n_bad++; $display("FAIL len_counts_%0d: got starts %0d errs %0d want 0 and 1", bad_len[i], start_cyc_q.size() - bs, lenerr_cnt - be);
            end
        end
        make_random(26, 1'b0);
        run_block(26, 1'b0, 1'b0, "len26");
    endtask

    task automatic test_partial_word();
        for (int i = 0; i < 3; i++) begin
            make_random(40, 1'($urandom_range(0, 1)));
            run_block(40, 1'b0, 1'b0, "partial40");
        end
    endtask

    task automatic test_busy_start_ignored();
        make_random(100, 1'b0);
        run_block(100, 1'b0, 1'b1, "busy_start");
    endtask

    task automatic test_reset_mid_feed();
        int n_acc, bd;
        make_random(200, 1'b0);
        bd = done_cyc_q.size();
        n_acc = 0;
        start_block(200);
        repeat (12) feed_cycle(1'b0, n_acc);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rst_mid busy_before: got %b want 1", busy); end
        #2; rstn = 1'b0;
        #1;
        n_cmp++; if ({word_rdy, crc_decode_start, din, din_vld, parity_vld, busy, cb_done, cb_crc_fail, len_err} !== 10'b0) begin
            n_bad++; $display("FAIL rst_mid outputs: got %b want 0", {word_rdy, crc_decode_start, din, din_vld, parity_vld, busy, cb_done, cb_crc_fail, len_err});
        end
        word_vld = 1'b0;
        @(posedge clk); #1; rstn = 1'b1;
        repeat (60) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (done_cyc_q.size() - bd !== 0) begin n_bad++; $display("FAIL rst_mid done_pulses: got %0d want 0", done_cyc_q.size() - bd); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_mid busy_after: got %b want 0", busy); end
        last_exp_fail = 1'b0;
        make_random(60, 1'b1);
        run_block(60, 1'b0, 1'b0, "after_reset");
    endtask

`ifdef PDSCH_CRC_FEED_ABORT_EN
    task automatic test_abort();
        int n_acc, bd;
        bit prev_fail;
        prev_fail = last_exp_fail;
        make_random(200, 1'($urandom_range(0, 1)));
        bd = done_cyc_q.size();
        n_acc = 0;
        start_block(200);
        repeat (12) feed_cycle(1'b0, n_acc);
        abort = 1'b1;
        @(posedge clk); #1; abort = 1'b0;
        @(negedge clk);
        n_cmp++; if ({busy, din_vld, word_rdy} !== 3'b0) begin n_bad++; $display("FAIL abort idle: got %b want 000", {busy, din_vld, word_rdy}); end
        word_vld = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (done_cyc_q.size() - bd !== 0) begin n_bad++; $display("FAIL abort done_pulses: got %0d want 0", done_cyc_q.size() - bd); end
        n_cmp++; if (cb_crc_fail !== prev_fail) begin n_bad++; $display("FAIL abort crc_fail_kept: got %b want %b", cb_crc_fail, prev_fail); end
        make_random(56, 1'($urandom_range(0, 1)));
        run_block(56, 1'b0, 1'b0, "after_abort");
    endtask
`endif

    initial begin
        test_reset();
        test_basic_len56();
        test_crc_pass_fail();
        test_bubbles();
        test_len_check();
        test_partial_word();
        test_busy_start_ignored();
        test_reset_mid_feed();
`ifdef PDSCH_CRC_FEED_ABORT_EN
        test_abort();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
